// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational instruction memory (slave).
interface instruction_fetch_if;
    logic [15:0] imem_addr;   // byte address driven by fetch (equals PC)
    logic [15:0] imem_instr;  // word returned combinationally for imem_addr

    modport master (
        output imem_addr,
        input  imem_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage of the 16-bit pipelined datapath.
// Owns the PC, drives the combinational instruction memory and captures
// the returned word into the IF/ID pipeline register.
//
// Handshake: if_id_valid marks the IF/ID contents as a real instruction
// (1) or a bubble (0). stall acts as the downstream not-ready: while it is
// high in RUN the PC and IF/ID hold, so nothing is lost or duplicated.
// A redirect always overrides stall and flushes IF/ID to a bubble.
//
// Per-edge priority: reset > redirect > HALTED hold > stall > normal fetch.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hEFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    instruction_fetch_if.master imem,
    output logic [15:0]         if_id_instr,
    output logic [15:0]         if_id_pc_plus2,
    output logic                if_id_valid,
    output logic                halted,
    output logic [15:0]         fetch_count,
    output logic                state_dbg
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;

    logic [15:0] pc_plus2;
    logic        fetch_ok;
    logic        is_halt;

    // PC increment wraps modulo 2^16 by construction.
    assign pc_plus2 = pc_q + 16'd2;
    assign is_halt  = (imem.imem_instr == HALT_WORD);
    // A fetch is accepted into IF/ID only when running, not stalled and
    // not being flushed by a redirect.
    assign fetch_ok = !redirect && (state_q == RUN) && !stall;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect restarts fetch, a fetched halt word stops it.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = RUN;
        end else if (fetch_ok && is_halt) begin
            state_d = HALTED;
        end
    end

    // PC and IF/ID next-value selection following the edge priority.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            // The word fetched this cycle is discarded; LSB of target forced 0.
            pc_d    = {redirect_pc[15:1], 1'b0};
            instr_d = NOP_WORD;
            pc2_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (fetch_ok) begin
            instr_d = imem.imem_instr;
            pc2_d   = pc_plus2;
            valid_d = 1'b1;
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
            // The halt word is delivered, but the PC stays on it.
            if (!is_halt) begin
                pc_d = pc_plus2;
            end
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc2_q;
    assign if_id_valid    = valid_q;
    assign fetch_count    = count_q;
    assign halted         = (state_q == HALTED);
    assign state_dbg      = state_q;

endmodule
